tl45_muldiv_seq: RTL and testbench
==================================

// Module: tl45_muldiv_seq
// PURPOSE
// - Sequencer for the multi-cycle ALU ops (MUL, DIV, UDIV). Sits between the ALU stage and the divider.
// - Captures operands and runs the multiply latency counter.
// - Issues a one-shot request to the divider and waits for its result.
// - Drives the stage stall, and delivers a single-cycle result with its destination register.
// - Absorbs pipeline flushes, including discarding a divide still in flight.
// PARAMETERS
// - MUL_LATENCY  5   cycles spent in MUL_WAIT before the product is taken (>=1; multicycle path on the multiplier)
// - DATA_W       32  operand/result width
// PORTS
// - i_clk         in   1       clock
// - i_reset       in   1       synchronous, active-high reset
// - i_op_valid    in   1       ALU stage holds a MUL/DIV/UDIV op; stays stable while o_stall=1
// - i_op_kind     in   2       0=MUL 1=DIV(signed) 2=UDIV 3=reserved
// - i_flush       in   1       pipeline flush; aborts the current op
// - i_a, i_b      in   DATA_W  operands (sr1, sr2)
// - i_dr          in   4       destination register
// - o_stall       out  1       hold the ALU stage and everything upstream
// - o_done        out  1       1-cycle pulse: o_result/o_dr/o_err valid
// - o_result      out  DATA_W  product low word, or quotient
// - o_dr          out  4       destination register of the completed op
// - o_err         out  1       divide error or reserved kind
// - o_div_wr      out  1       divider start strobe
// - o_div_signed  out  1       signed divide
// - o_div_a       out  DATA_W  latched operand a
// - o_div_b       out  DATA_W  latched operand b
// - i_div_busy    in   1       divider busy
// - i_div_valid   in   1       divider result strobe
// - i_div_err     in   1       divider error
// - i_div_result  in   DATA_W  divider quotient
// BEHAVIOUR
// - Reset: state=IDLE, cnt=0, drain=0, latched regs=0.
//   - All outputs 0, except o_stall, which follows i_op_valid.
// - FSM states: IDLE, MUL_WAIT, DIV_ISSUE, DIV_WAIT, DONE.
// - IDLE, i_op_valid & !i_flush:
//   - Latch a, b, dr, kind.
//   - kind 0 -> MUL_WAIT, cnt=0.
//   - kind 1/2 -> DIV_ISSUE, but only if drain=0 and i_div_busy=0; otherwise stay in IDLE.
//   - kind 3 -> DONE with err=1, result=0.
// - MUL_WAIT: cnt++ each cycle; at cnt==MUL_LATENCY-1 -> DONE, result = (a*b)[DATA_W-1:0].
//   - Latency: accepted in cycle 0, o_done in cycle MUL_LATENCY+1.
// - DIV_ISSUE: o_div_wr=1 for exactly this cycle, o_div_signed=(kind==1); then -> DIV_WAIT.
// - DIV_WAIT: on i_div_valid, capture i_div_result and i_div_err -> DONE.
//   - i_div_valid is never expected in DIV_ISSUE; it is ignored there.
// - DONE: o_done=1, outputs result/dr/err; o_stall=0 so the stage advances -> IDLE.
//   - Outside DONE, o_done/o_result/o_dr/o_err are all 0.
// - o_stall = i_op_valid & !i_flush & (state!=DONE).
//   - Consequence: the op presented in the cycle after DONE is a new instruction, so there is no re-issue.
// - Flush (any state): next state is IDLE and cnt=0; no o_done is ever produced for the aborted op.
//   - If the flush hits DIV_ISSUE or DIV_WAIT: drain=1, because the divider has no abort.
//   - A flush in the same cycle as i_div_valid in DIV_WAIT: the result is discarded and drain stays 0.
//   - A flush during DONE: o_done is suppressed that cycle.
// - drain=1: the next i_div_valid clears drain and its result is dropped; new divides wait in IDLE until then.
//   - MUL ops may proceed while drain=1.
// - Other i_div_valid pulses are ignored: in IDLE with drain=0, and in MUL_WAIT when no drain is pending.
// - i_reset mid-op: immediate return to IDLE, drain=0.
//   - Parent also resets the divider on i_reset, so no stale result arrives.
// STRUCTURE
// - tl45_pkg:
//   - typedef enum logic [1:0] md_kind_t {MD_MUL, MD_DIV, MD_UDIV, MD_RSVD}
//   - typedef enum md_state_t for the FSM
//   - MUL_LATENCY default constant shared with the ALU
// - No sub-module: the divider (div) is instantiated by the parent ALU and wired to the o_div_* / i_div_* ports.
// TESTING
// - MUL a=7 b=6 dr=3, MUL_LATENCY=5: o_stall=1 in cycles 0-5; o_done in cycle 6 with result=42, dr=3.
// - MUL a=0xFFFFFFFF b=2: result=0xFFFFFFFE, o_err=0; with i_op_valid held low afterwards, o_done pulses exactly once.
// - DIV a=-20 b=3, 10-cycle divider model: o_div_wr is one pulse in cycle 1 with o_div_signed=1;
//   o_done the cycle after i_div_valid with result=0xFFFFFFFA.
// - UDIV a=9 b=0, model asserts i_div_err: o_done with o_err=1, dr forwarded, o_stall released the same cycle.
// - DIV flushed in cycle 4, new DIV presented in cycle 5: no o_done for the old op;
//   o_div_wr stays 0 until the stale i_div_valid, then the new divide issues and completes normally.
// - i_reset in MUL_WAIT cycle 3: next cycle state=IDLE and all outputs 0; a following MUL 2*3 returns 6 at the full latency.

Source files
------------

// File: rtl/tl45_pkg.sv
// Shared types and constants for the TL45 multi-cycle ALU sequencer.
//   md_kind_t  : operation kind as presented by the ALU stage
//   md_state_t : sequencer FSM state
//   MD_MUL_LATENCY : default multiplier latency, also used by the ALU
package tl45_pkg;

  localparam int unsigned MD_MUL_LATENCY = 5;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIV  = 2'd1,
    MD_UDIV = 2'd2,
    MD_RSVD = 2'd3
  } md_kind_t;

  typedef enum logic [2:0] {
    StIdle,
    StMulWait,
    StDivIssue,
    StDivWait,
    StDone
  } md_state_t;

endpackage

// File: rtl/tl45_muldiv_seq_if.sv
// Bundle between the ALU stage / divider and the mul/div sequencer.
//   Op side   : i_op_valid, i_op_kind, i_flush, i_a, i_b, i_dr -> o_stall, o_done,
//               o_result, o_dr, o_err
//   Div side  : o_div_wr, o_div_signed, o_div_a, o_div_b <- i_div_busy, i_div_valid,
//               i_div_err, i_div_result
// The slave modport is the sequencer; master is the parent ALU (or a testbench).
interface tl45_muldiv_seq_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              i_op_valid;
  logic [1:0]        i_op_kind;
  logic              i_flush;
  logic [DATA_W-1:0] i_a;
  logic [DATA_W-1:0] i_b;
  logic [3:0]        i_dr;
  logic              o_stall;
  logic              o_done;
  logic [DATA_W-1:0] o_result;
  logic [3:0]        o_dr;
  logic              o_err;
  logic              o_div_wr;
  logic              o_div_signed;
  logic [DATA_W-1:0] o_div_a;
  logic [DATA_W-1:0] o_div_b;
  logic              i_div_busy;
  logic              i_div_valid;
  logic              i_div_err;
  logic [DATA_W-1:0] i_div_result;

  modport slave (
    input  i_op_valid, i_op_kind, i_flush, i_a, i_b, i_dr,
    input  i_div_busy, i_div_valid, i_div_err, i_div_result,
    output o_stall, o_done, o_result, o_dr, o_err,
    output o_div_wr, o_div_signed, o_div_a, o_div_b
  );

  modport master (
    output i_op_valid, i_op_kind, i_flush, i_a, i_b, i_dr,
    output i_div_busy, i_div_valid, i_div_err, i_div_result,
    input  o_stall, o_done, o_result, o_dr, o_err,
    input  o_div_wr, o_div_signed, o_div_a, o_div_b
  );

endinterface

// File: rtl/tl45_muldiv_seq.sv
// Sequencer for the multi-cycle ALU ops (MUL, DIV, UDIV).
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus (slave)    : op request/response towards the ALU stage, strobe/result towards
//                    the external divider
// MUL runs a latency counter over a multicycle multiplier path; DIV/UDIV issue a one-shot
// start to the divider and wait for its result strobe. A flush aborts the current op; a
// divide already started cannot be aborted, so its late result is drained and dropped.
module tl45_muldiv_seq
  import tl45_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = MD_MUL_LATENCY,
  parameter int unsigned DATA_W      = 32
) (
  input logic               i_clk,
  input logic               i_reset,
  tl45_muldiv_seq_if.slave  bus
);

  localparam int unsigned CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MUL_LATENCY - 1);

  md_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drain_q, drain_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]        dr_q, dr_d;
  md_kind_t          kind_q, kind_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] prod;
  logic              done;
  md_kind_t          kind_in;

  assign prod    = a_q * b_q;
  assign kind_in = md_kind_t'(bus.i_op_kind);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    a_d      = a_q;
    b_d      = b_q;
    dr_d     = dr_q;
    kind_d   = kind_q;
    result_d = result_q;
    err_d    = err_q;

    // The first result strobe after an aborted divide belongs to that divide.
    if (drain_q && bus.i_div_valid) drain_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.i_op_valid && !bus.i_flush) begin
          a_d    = bus.i_a;
          b_d    = bus.i_b;
          dr_d   = bus.i_dr;
          kind_d = kind_in;
          unique case (kind_in)
            MD_MUL: begin
              state_d = StMulWait;
              cnt_d   = '0;
            end
            MD_DIV, MD_UDIV: begin
              if (!drain_q && !bus.i_div_busy) state_d = StDivIssue;
            end
            default: begin
              state_d  = StDone;
              result_d = '0;
              err_d    = 1'b1;
            end
          endcase
        end
      end
      StMulWait: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d  = StDone;
          result_d = prod;
          err_d    = 1'b0;
        end
      end
      StDivIssue: state_d = StDivWait;
      StDivWait: begin
        if (bus.i_div_valid) begin
          state_d  = StDone;
          result_d = bus.i_div_result;
          err_d    = bus.i_div_err;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (bus.i_flush) begin
      state_d = StIdle;
      cnt_d   = '0;
      // Divider already started and has no abort; a result arriving this very cycle is
      // simply discarded and leaves nothing to drain.
      if (state_q == StDivIssue || (state_q == StDivWait && !bus.i_div_valid)) begin
        drain_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      drain_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      dr_q     <= '0;
      kind_q   <= MD_MUL;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dr_q     <= dr_d;
      kind_q   <= kind_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    done             = (state_q == StDone) && !bus.i_flush;
    bus.o_done       = done;
    bus.o_result     = done ? result_q : '0;
    bus.o_dr         = done ? dr_q : '0;
    bus.o_err        = done && err_q;
    // Releasing the stall in DONE lets the stage advance, so the next op is a new one.
    bus.o_stall      = bus.i_op_valid && !bus.i_flush && (state_q != StDone);
    bus.o_div_wr     = (state_q == StDivIssue);
    bus.o_div_signed = (state_q == StDivIssue) && (kind_q == MD_DIV);
    bus.o_div_a      = a_q;
    bus.o_div_b      = b_q;
  end

endmodule

// File: tb/tb_tl45_muldiv_seq.sv
// Self-checking bench for tl45_muldiv_seq with a behavioural fixed-latency divider.
module tb_tl45_muldiv_seq;

  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tl45_muldiv_seq_if #(.DATA_W(32)) bus ();

  tl45_muldiv_seq #(.MUL_LATENCY(MUL_LAT), .DATA_W(32)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference arithmetic: {err, result}
  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    int sa, sb;
    if (b == 0) return {1'b1, 32'd0};
    if (sgn) begin
      sa = a;
      sb = b;
      if (sa == 32'sh8000_0000 && sb == -1) return {1'b0, a};
      return {1'b0, 32'(sa / sb)};
    end
    return {1'b0, a / b};
  endfunction

  function automatic logic [32:0] ref_op(input logic [1:0] k, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    case (k)
      2'd0: begin
        p = 64'(a) * 64'(b);
        return {1'b0, p[31:0]};
      end
      2'd1:    return ref_div(a, b, 1'b1);
      2'd2:    return ref_div(a, b, 1'b0);
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] k);
    case (k)
      2'd0:    return MUL_LAT + 1;
      2'd3:    return 1;
      default: return DIV_LAT + 2;
    endcase
  endfunction

  // Divider model: start seen during a cycle, result strobe DIV_LAT cycles later.
  int          mdl_cnt = 0;
  logic        mdl_busy = 1'b0;
  logic        mdl_rst;
  logic [31:0] mdl_a, mdl_b;
  logic        mdl_sgn;
  logic [32:0] mdl_r;
  always begin
    @(negedge clk);
    mdl_rst = rst;
    if (!rst && bus.o_div_wr && !mdl_busy) begin
      mdl_busy = 1'b1;
      mdl_cnt  = DIV_LAT;
      mdl_a    = bus.o_div_a;
      mdl_b    = bus.o_div_b;
      mdl_sgn  = bus.o_div_signed;
    end
    @(posedge clk);
    #1;
    bus.i_div_valid  = 1'b0;
    bus.i_div_err    = 1'b0;
    bus.i_div_result = '0;
    if (mdl_rst) begin
      mdl_busy = 1'b0;
    end else if (mdl_busy) begin
      mdl_cnt--;
      if (mdl_cnt == 0) begin
        mdl_r            = ref_div(mdl_a, mdl_b, mdl_sgn);
        bus.i_div_valid  = 1'b1;
        bus.i_div_err    = mdl_r[32];
        bus.i_div_result = mdl_r[31:0];
        mdl_busy         = 1'b0;
      end
    end
    bus.i_div_busy = mdl_busy;
  end

  // Results of the last run_op
  int          dc, wcnt, wcyc, vc, sbad;
  logic [31:0] r, wa;
  logic [3:0]  rd;
  logic        e, ws;

  // Presents one op from cycle 0 (call just after a rising edge) and holds it until o_done.
  task automatic run_op(input logic [1:0] k, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] dr);
    dc = -1; wcnt = 0; wcyc = -1; vc = -1; sbad = 0;
    r = '0; rd = '0; e = 1'b0; ws = 1'b0; wa = '0;
    bus.i_op_valid = 1'b1;
    bus.i_op_kind  = k;
    bus.i_a        = a;
    bus.i_b        = b;
    bus.i_dr       = dr;
    for (int c = 0; c < 300 && dc < 0; c++) begin
      @(negedge clk);
      if (bus.o_div_wr) begin
        wcnt++;
        wcyc = c;
        ws   = bus.o_div_signed;
        wa   = bus.o_div_a;
      end
      if (bus.i_div_valid && vc < 0) vc = c;
      if (bus.o_done) begin
        dc = c;
        r  = bus.o_result;
        rd = bus.o_dr;
        e  = bus.o_err;
        if (bus.o_stall !== 1'b0) sbad++;
      end else if (bus.o_stall !== 1'b1) begin
        sbad++;
      end
      @(posedge clk);
      #1;
    end
    bus.i_op_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.i_op_valid = 1'b1;
    bus.i_op_kind  = 2'd0;
    bus.i_a        = 32'd5;
    bus.i_b        = 32'd9;
    bus.i_dr       = 4'd7;
    idle_cycles(2);
    @(negedge clk);
    checks++; if (bus.o_stall !== 1'b1) begin failures++; $display("FAIL reset_stall_follows: got %b want 1", bus.o_stall); end
    checks++; if (bus.o_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
    checks++; if (bus.o_result !== 32'd0) begin failures++; $display("FAIL reset_result: got %h want 0", bus.o_result); end
    checks++; if ({bus.o_dr, bus.o_err} !== 5'd0) begin failures++; $display("FAIL reset_dr_err: got %h want 0", {bus.o_dr, bus.o_err}); end
    checks++; if ({bus.o_div_wr, bus.o_div_signed} !== 2'b00) begin failures++; $display("FAIL reset_div_ctl: got %b want 00", {bus.o_div_wr, bus.o_div_signed}); end
    checks++; if ({bus.o_div_a, bus.o_div_b} !== 64'd0) begin failures++; $display("FAIL reset_div_ops: got %h want 0", {bus.o_div_a, bus.o_div_b}); end
    @(posedge clk); #1;
    bus.i_op_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall_low: got %b want 0", bus.o_stall); end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_mul_basic;
    run_op(2'd0, 32'd7, 32'd6, 4'd3);
    checks++; if (dc !== 6) begin failures++; $display("FAIL mul_latency: got %0d want 6", dc); end
    checks++; if (r !== 32'd42) begin failures++; $display("FAIL mul_result: got %0d want 42", r); end
    checks++; if (rd !== 4'd3) begin failures++; $display("FAIL mul_dr: got %0d want 3", rd); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL mul_err: got %b want 0", e); end
    checks++; if (sbad !== 0) begin failures++; $display("FAIL mul_stall: got %0d bad cycles want 0", sbad); end
    checks++; if (wcnt !== 0) begin failures++; $display("FAIL mul_no_div_wr: got %0d want 0", wcnt); end
  endtask

  task automatic test_mul_wrap;
    int extra;
    run_op(2'd0, 32'hFFFF_FFFF, 32'd2, 4'd1);
    checks++; if (r !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulwrap_result: got %h want fffffffe", r); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL mulwrap_err: got %b want 0", e); end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_done) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL mulwrap_single_done: got %0d extra pulses want 0", extra); end
    idle_cycles(1);
  endtask

  task automatic test_div_signed;
    run_op(2'd1, 32'hFFFF_FFEC, 32'd3, 4'd5);
    checks++; if (wcnt !== 1 || wcyc !== 1) begin failures++; $display("FAIL div_wr_pulse: got %0d pulses at cycle %0d want 1 at 1", wcnt, wcyc); end
    checks++; if (ws !== 1'b1) begin failures++; $display("FAIL div_signed: got %b want 1", ws); end
    checks++; if (wa !== 32'hFFFF_FFEC) begin failures++; $display("FAIL div_a: got %h want ffffffec", wa); end
    checks++; if (vc < 0 || dc !== vc + 1) begin failures++; $display("FAIL div_done_timing: got %0d want %0d", dc, vc + 1); end
    checks++; if (r !== 32'hFFFF_FFFA) begin failures++; $display("FAIL div_result: got %h want fffffffa", r); end
    checks++; if (rd !== 4'd5 || e !== 1'b0) begin failures++; $display("FAIL div_dr_err: got %0d/%b want 5/0", rd, e); end
  endtask

  task automatic test_udiv_zero;
    run_op(2'd2, 32'd9, 32'd0, 4'd11);
    checks++; if (ws !== 1'b0) begin failures++; $display("FAIL udiv_signed: got %b want 0", ws); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL udiv_err: got %b want 1", e); end
    checks++; if (rd !== 4'd11) begin failures++; $display("FAIL udiv_dr: got %0d want 11", rd); end
    checks++; if (sbad !== 0) begin failures++; $display("FAIL udiv_stall: got %0d bad cycles want 0", sbad); end
  endtask

  task automatic test_flush_div;
    int done_cnt, wr_before, wr_after, wr_new_cyc, stale, got_cyc;
    logic [31:0] got_r;
    logic [3:0]  got_dr;
    logic        stall_at_flush;
    done_cnt = 0; wr_before = 0; wr_after = 0; wr_new_cyc = -1; stale = -1; got_cyc = -1;
    got_r = '0; got_dr = '0; stall_at_flush = 1'b1;
    bus.i_op_valid = 1'b1;
    bus.i_op_kind  = 2'd1;
    bus.i_a        = 32'd100;
    bus.i_b        = 32'd7;
    bus.i_dr       = 4'd2;
    for (int c = 0; c < 300 && got_cyc < 0; c++) begin
      if (c == 4) bus.i_flush = 1'b1;
      if (c == 5) begin
        bus.i_flush = 1'b0;
        bus.i_a     = 32'hFFFF_FFCE;
        bus.i_b     = 32'd5;
        bus.i_dr    = 4'd9;
      end
      @(negedge clk);
      if (c == 4) stall_at_flush = bus.o_stall;
      if (bus.o_done) begin
        done_cnt++;
        got_r  = bus.o_result;
        got_dr = bus.o_dr;
        if (c >= 5) got_cyc = c;
      end
      if (c >= 4 && bus.i_div_valid && stale < 0) stale = c;
      else if (c >= 4 && bus.o_div_wr) begin
        if (stale < 0) wr_before++;
        else begin
          wr_after++;
          wr_new_cyc = c;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.i_op_valid = 1'b0;
    checks++; if (stall_at_flush !== 1'b0) begin failures++; $display("FAIL flush_stall: got %b want 0", stall_at_flush); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL flush_done_count: got %0d want 1", done_cnt); end
    checks++; if (wr_before !== 0) begin failures++; $display("FAIL flush_wr_early: got %0d want 0", wr_before); end
    checks++; if (stale < 0 || wr_after !== 1 || wr_new_cyc !== stale + 2) begin failures++; $display("FAIL flush_reissue: got %0d pulses at %0d want 1 at %0d", wr_after, wr_new_cyc, stale + 2); end
    checks++; if (got_r !== 32'hFFFF_FFF6) begin failures++; $display("FAIL flush_new_result: got %h want fffffff6", got_r); end
    checks++; if (got_dr !== 4'd9) begin failures++; $display("FAIL flush_new_dr: got %0d want 9", got_dr); end
    idle_cycles(2);
  endtask

  task automatic test_flush_done;
    int extra;
    logic d6;
    logic [31:0] r6;
    bus.i_op_valid = 1'b1;
    bus.i_op_kind  = 2'd0;
    bus.i_a        = 32'd3;
    bus.i_b        = 32'd3;
    bus.i_dr       = 4'd4;
    idle_cycles(6);
    bus.i_flush = 1'b1;
    @(negedge clk);
    d6 = bus.o_done;
    r6 = bus.o_result;
    @(posedge clk); #1;
    bus.i_flush    = 1'b0;
    bus.i_op_valid = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.o_done) extra++;
    end
    checks++; if (d6 !== 1'b0 || r6 !== 32'd0) begin failures++; $display("FAIL flushdone_suppress: got %b/%h want 0/0", d6, r6); end
    checks++; if (extra !== 0) begin failures++; $display("FAIL flushdone_later: got %0d want 0", extra); end
    idle_cycles(1);
  endtask

  task automatic test_mul_during_drain;
    bus.i_op_valid = 1'b1;
    bus.i_op_kind  = 2'd2;
    bus.i_a        = 32'd50;
    bus.i_b        = 32'd5;
    bus.i_dr       = 4'd1;
    idle_cycles(2);
    bus.i_flush = 1'b1;
    idle_cycles(1);
    bus.i_flush = 1'b0;
    run_op(2'd0, 32'd3, 32'd4, 4'd6);
    checks++; if (dc !== 6 || r !== 32'd12) begin failures++; $display("FAIL drain_mul: got %0d at %0d want 12 at 6", r, dc); end
    checks++; if (rd !== 4'd6) begin failures++; $display("FAIL drain_mul_dr: got %0d want 6", rd); end
    idle_cycles(6);
    run_op(2'd2, 32'd7, 32'd2, 4'd8);
    checks++; if (r !== 32'd3 || e !== 1'b0) begin failures++; $display("FAIL drain_div_result: got %h/%b want 3/0", r, e); end
    checks++; if (dc !== int'(DIV_LAT) + 2) begin failures++; $display("FAIL drain_div_latency: got %0d want %0d", dc, DIV_LAT + 2); end
  endtask

  task automatic test_reset_mid_mul;
    logic [3:0]  flags;
    logic [31:0] res4;
    logic [63:0] ops4;
    int pre_done;
    pre_done = 0;
    bus.i_op_valid = 1'b1;
    bus.i_op_kind  = 2'd0;
    bus.i_a        = 32'd5;
    bus.i_b        = 32'd5;
    bus.i_dr       = 4'd2;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) rst = 1'b1;
      @(negedge clk);
      if (bus.o_done) pre_done++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    bus.i_op_valid = 1'b0;
    @(negedge clk);
    flags = {bus.o_done, bus.o_stall, bus.o_err, bus.o_div_wr};
    res4  = bus.o_result | 32'(bus.o_dr);
    ops4  = {bus.o_div_a, bus.o_div_b};
    @(posedge clk); #1;
    checks++; if (pre_done !== 0) begin failures++; $display("FAIL rst_mid_no_done: got %0d want 0", pre_done); end
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL rst_mid_flags: got %b want 0000", flags); end
    checks++; if (res4 !== 32'd0) begin failures++; $display("FAIL rst_mid_result: got %h want 0", res4); end
    checks++; if (ops4 !== 64'd0) begin failures++; $display("FAIL rst_mid_latched: got %h want 0", ops4); end
    run_op(2'd0, 32'd2, 32'd3, 4'd10);
    checks++; if (dc !== 6 || r !== 32'd6) begin failures++; $display("FAIL rst_mid_next_mul: got %0d at %0d want 6 at 6", r, dc); end
  endtask

  task automatic test_random;
    logic [1:0]  k;
    logic [31:0] a, b;
    logic [3:0]  dr;
    logic [32:0] exp;
    for (int i = 0; i < 24; i++) begin
      k  = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 28);
      dr = 4'($urandom);
      exp = ref_op(k, a, b);
      run_op(k, a, b, dr);
      checks++; if ({e, r} !== exp) begin failures++; $display("FAIL rand_result[%0d] kind %0d: got %b/%h want %b/%h", i, k, e, r, exp[32], exp[31:0]); end
      checks++; if (rd !== dr) begin failures++; $display("FAIL rand_dr[%0d]: got %0d want %0d", i, rd, dr); end
      checks++; if (dc !== ref_lat(k)) begin failures++; $display("FAIL rand_latency[%0d] kind %0d: got %0d want %0d", i, k, dc, ref_lat(k)); end
      idle_cycles($urandom_range(0, 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_op_valid   = 1'b0;
    bus.i_op_kind    = 2'd0;
    bus.i_flush      = 1'b0;
    bus.i_a          = '0;
    bus.i_b          = '0;
    bus.i_dr         = '0;
    bus.i_div_busy   = 1'b0;
    bus.i_div_valid  = 1'b0;
    bus.i_div_err    = 1'b0;
    bus.i_div_result = '0;
    test_reset();
    test_mul_basic();
    test_mul_wrap();
    test_div_signed();
    test_udiv_zero();
    test_flush_div();
    test_flush_done();
    test_mul_during_drain();
    test_reset_mid_mul();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
